// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bridge-side bundle of the buffered UART transmitter.
// master = byte producer, slave = transmitter.
interface uart_tx_fifo_if;
  logic [7:0] DATA_IN;
  logic       WRITE_EN;
  logic       FIFO_FULL;
  logic       FIFO_EMPTY;
  logic       TX_BUSY;
  logic       OVERFLOW;
  logic       TRANSMITTED_8_BITS_FLAG;
  logic       TX_PIN;

  modport master (
    output DATA_IN,
    output WRITE_EN,
    input  FIFO_FULL,
    input  FIFO_EMPTY,
    input  TX_BUSY,
    input  OVERFLOW,
    input  TRANSMITTED_8_BITS_FLAG,
    input  TX_PIN
  );

  modport slave (
    input  DATA_IN,
    input  WRITE_EN,
    output FIFO_FULL,
    output FIFO_EMPTY,
    output TX_BUSY,
    output OVERFLOW,
    output TRANSMITTED_8_BITS_FLAG,
    output TX_PIN
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 transmitter.
// Small FIFO in front of a serialiser with registered line output.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 864,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input logic           MAIN_CLOCK,
  input logic           RESET,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE =
    BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]              cnt;
  state_t                     state;
  logic [7:0]                 shift;
  logic [2:0]                 bit_idx;
  logic [BW-1:0]              baud;
  logic                       tx_q;
  logic                       flag_q;
  logic                       busy_q;
  logic                       ovf_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic baud_end;

  assign full     = (cnt == CNT_FULL);
  assign empty    = (cnt == '0);
  assign push     = bus.WRITE_EN && !full;
  assign pop      = (state == IDLE) && !empty;
  assign baud_end = (baud == BAUD_LAST);

  assign bus.FIFO_FULL               = full;
  assign bus.FIFO_EMPTY              = empty;
  assign bus.TX_BUSY                 = busy_q;
  assign bus.OVERFLOW                = ovf_q;
  assign bus.TRANSMITTED_8_BITS_FLAG = flag_q;
  assign bus.TX_PIN                  = tx_q;

  // Byte storage; contents need no reset.
  always_ff @(posedge MAIN_CLOCK) begin
    if (push) mem[wr_ptr] <= bus.DATA_IN;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (bus.WRITE_EN && full) ovf_q <= 1'b1;
    end
  end

  // Frame sequencer with registered line, busy and flag.
  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      baud    <= '0;
      tx_q    <= 1'b1;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      flag_q <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            bit_idx <= '0;
            baud    <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud  <= '0;
            tx_q  <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
              tx_q    <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud   <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            baud   <= baud + 1'b1;
            flag_q <= (baud == BAUD_PRE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for the buffered UART transmitter.
// Fast instance tracked by a frame-level model; default-rate instance checked directly.
module tb_uart_tx_fifo;
  localparam int CA    = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   flag_cnt_a = 0;

  uart_tx_fifo_if bus_a();
  uart_tx_fifo_if bus_b();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CA),
    .FIFO_DEPTH_LOG2(2)
  ) dut_a (
    .MAIN_CLOCK(clk),
    .RESET(rst),
    .bus(bus_a)
  );

  uart_tx_fifo dut_b (
    .MAIN_CLOCK(clk),
    .RESET(rst),
    .bus(bus_b)
  );

  always #5 clk = ~clk;

  // model: queue of accepted bytes plus position inside the current frame
  logic [7:0] mq[$];
  logic [7:0] m_cur = '0;
  bit         m_in = 1'b0;
  int         m_p = 0;
  bit         m_ovf = 1'b0;
  bit         m_pre_full;
  bit         m_go;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_in  = 1'b0;
        m_p   = 0;
        m_ovf = 1'b0;
      end else begin
        m_pre_full = (mq.size() == DEPTH);
        m_go       = !m_in && (mq.size() != 0);
        if (m_in) begin
          m_p++;
          if (m_p == FRAME) m_in = 1'b0;
        end else if (m_go) begin
          m_cur = mq.pop_front();
          m_in  = 1'b1;
          m_p   = 0;
        end
        if (bus_a.WRITE_EN) begin
          if (m_pre_full) m_ovf = 1'b1;
          else mq.push_back(bus_a.DATA_IN);
        end
      end
    end
  end

  // per-cycle comparison of the fast instance against the model
  initial begin
    logic e_tx;
    int   bi;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bi   = m_p / CA;
        e_tx = 1'b1;
        if (m_in && bi == 0) e_tx = 1'b0;
        else if (m_in && bi <= 8) e_tx = m_cur[bi-1];
        chk("model",
            {26'd0, bus_a.TX_PIN,
             bus_a.TRANSMITTED_8_BITS_FLAG,
             bus_a.TX_BUSY, bus_a.FIFO_EMPTY,
             bus_a.FIFO_FULL, bus_a.OVERFLOW},
            {26'd0, e_tx,
             m_in && (m_p == FRAME - 1),
             m_in, mq.size() == 0,
             mq.size() == DEPTH, m_ovf});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus_a.TRANSMITTED_8_BITS_FLAG) flag_cnt_a++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic line(input bit use_b);
    return use_b ? bus_b.TX_PIN : bus_a.TX_PIN;
  endfunction

  function automatic logic flag(input bit use_b);
    return use_b ? bus_b.TRANSMITTED_8_BITS_FLAG
                 : bus_a.TRANSMITTED_8_BITS_FLAG;
  endfunction

  function automatic logic busy(input bit use_b);
    return use_b ? bus_b.TX_BUSY : bus_a.TX_BUSY;
  endfunction

  task automatic burst_a(input logic [7:0] d[$]);
    foreach (d[i]) begin
      @(negedge clk);
      bus_a.DATA_IN  = d[i];
      bus_a.WRITE_EN = 1'b1;
    end
    @(negedge clk);
    bus_a.WRITE_EN = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] d);
    @(negedge clk);
    bus_b.DATA_IN  = d;
    bus_b.WRITE_EN = 1'b1;
    @(negedge clk);
    bus_b.WRITE_EN = 1'b0;
  endtask

  // entered on the first start-bit cycle
  task automatic check_frame(input bit use_b, input int c,
                             input logic [7:0] d,
                             input string tag);
    logic [9:0] fr;
    int bad;
    int fl;
    int fpos;
    fr   = {1'b1, d, 1'b0};
    fl   = 0;
    fpos = -1;
    for (int bi = 0; bi < 10; bi++) begin
      bad = 0;
      for (int k = 0; k < c; k++) begin
        if (bi != 0 || k != 0) @(negedge clk);
        if (line(use_b) !== fr[bi]) bad++;
        if (flag(use_b)) begin
          fl++;
          fpos = bi * c + k;
        end
      end
      chk($sformatf("%s_bit%0d", tag, bi), bad, 0);
    end
    chk({tag, "_flag_n"}, fl, 1);
    chk({tag, "_flag_pos"}, fpos, 10 * c - 1);
    @(negedge clk);
    chk({tag, "_after"},
        {line(use_b), busy(use_b), flag(use_b)},
        3'b100);
  endtask

  task automatic rx_from_start_a(output logic [7:0] b);
    b = '0;
    for (int p = 1; p < FRAME; p++) begin
      @(negedge clk);
      if (p % CA == CA / 2 && p >= CA && p < 9 * CA)
        b[p/CA-1] = bus_a.TX_PIN;
    end
  endtask

  task automatic rx_byte_a(output logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_a.TX_PIN && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rx_start", bus_a.TX_PIN, 0);
    rx_from_start_a(b);
  endtask

  initial begin
    logic [7:0] v[$];
    logic [7:0] b1;
    logic [7:0] b2;
    int f0;
    int gap;
    int lows;
    int fl;
    int n;

    bus_a.DATA_IN  = '0;
    bus_a.WRITE_EN = 1'b0;
    bus_b.DATA_IN  = '0;
    bus_b.WRITE_EN = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_a_outs",
        {bus_a.TX_PIN, bus_a.FIFO_EMPTY,
         bus_a.FIFO_FULL, bus_a.TX_BUSY,
         bus_a.OVERFLOW,
         bus_a.TRANSMITTED_8_BITS_FLAG},
        6'b110000);
    chk("rst_b_outs",
        {bus_b.TX_PIN, bus_b.FIFO_EMPTY,
         bus_b.TX_BUSY, bus_b.OVERFLOW},
        4'b1100);
    #2 rst = 1'b0;

    // single byte at four clocks per bit
    v = '{8'hA5};
    burst_a(v);
    chk("a5_pre_fall", bus_a.TX_PIN, 1);
    @(negedge clk);
    chk("a5_fall", bus_a.TX_PIN, 0);
    check_frame(1'b0, CA, 8'hA5, "a5");

    // fill to full, one byte dropped
    v  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    f0 = flag_cnt_a;
    fork
      begin
        burst_a(v);
        chk("fill_full", bus_a.FIFO_FULL, 1);
        chk("fill_ovf", bus_a.OVERFLOW, 1);
        chk("model_ovf", m_ovf, 1);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          rx_byte_a(b1);
          chk($sformatf("fill_byte%0d", i), b1, i + 1);
        end
      end
    join
    @(negedge clk);
    chk("fill_flags", flag_cnt_a - f0, 5);
    chk("fill_empty", bus_a.FIFO_EMPTY, 1);

    // second write lands on the pop edge
    v = '{8'h3C, 8'hC3};
    fork
      begin
        burst_a(v);
        chk("simul_empty", bus_a.FIFO_EMPTY, 0);
        chk("simul_full", bus_a.FIFO_FULL, 0);
      end
      begin
        rx_byte_a(b1);
        rx_byte_a(b2);
        chk("simul_b1", b1, 8'h3C);
        chk("simul_b2", b2, 8'hC3);
      end
    join

    // back-to-back gap
    v = '{8'h00, 8'hFF};
    fork
      burst_a(v);
      begin
        rx_byte_a(b1);
        gap = CA;
        @(negedge clk);
        while (bus_a.TX_PIN && gap < 40) begin
          gap++;
          @(negedge clk);
        end
        chk("b2b_gap", gap, CA + 1);
        rx_from_start_a(b2);
        chk("b2b_b1", b1, 8'h00);
        chk("b2b_b2", b2, 8'hFF);
      end
    join

    // reset in the middle of a frame with bytes queued
    v = '{8'h11, 8'h22, 8'h33, 8'h44};
    burst_a(v);
    repeat (8) @(negedge clk);
    chk("pre_rst_ovf", bus_a.OVERFLOW, 1);
    chk("pre_rst_busy", bus_a.TX_BUSY, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs",
        {bus_a.TX_PIN, bus_a.FIFO_EMPTY,
         bus_a.FIFO_FULL, bus_a.TX_BUSY,
         bus_a.OVERFLOW},
        5'b11000);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    lows = 0;
    fl   = 0;
    repeat (60) begin
      @(negedge clk);
      if (!bus_a.TX_PIN) lows++;
      if (bus_a.TRANSMITTED_8_BITS_FLAG) fl++;
    end
    chk("post_rst_lows", lows, 0);
    chk("post_rst_flags", fl, 0);
    chk("post_rst_empty", bus_a.FIFO_EMPTY, 1);

    // default rate frame
    write_b(8'h0F);
    n = 0;
    @(negedge clk);
    while (bus_b.TX_PIN && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("dflt_fall", n, 0);
    check_frame(1'b1, 864, 8'h0F, "dflt");

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
